// File: rtl/dat_fill_ctrl.sv
// dat_fill_ctrl -- DAT region fill engine with CPU-programmable registers.
//
// The CPU loads start address, entry count and fill value, then writes
// ctrl.start. The engine then writes one DAT low-byte entry per cycle in
// which the CPU is not using the DAT port. The value is either constant or
// incrementing. ctrl.abort stops the fill early with no done pulse.
//
// Optional feature (macro DAT_FILL_VERIFY_EN): after the last write the
// engine rereads the same range. It compares each byte against the expected
// value and sets a sticky err flag on any mismatch.
//
// Ports:
//   e            clock, rising edge
//   _reset       async active-low reset
//   reg_we       CPU register write strobe
//   reg_sel      register select (0 start_lo,1 start_hi,2 count,3 ctrl/status,4 value)
//   reg_wdata    register write data
//   reg_rdata    combinational readback of selected register
//   cpu_dat_req  CPU owns the DAT port this cycle (priority)
//   dat_owner    engine drives the DAT port
//   address_dat  DAT entry address
//   data_dat_out fill data for the DAT low byte
//   data_dat_in  DAT low-byte read data (async SRAM)
//   we_dat_l     low-byte write enable, active high
//   done         one-cycle pulse on normal completion
module dat_fill_ctrl (
   input  logic        e,
   input  logic        _reset,
   input  logic        reg_we,
   input  logic [2:0]  reg_sel,
   input  logic [7:0]  reg_wdata,
   output logic [7:0]  reg_rdata,
   input  logic        cpu_dat_req,
   output logic        dat_owner,
   output logic [14:0] address_dat,
   output logic [7:0]  data_dat_out,
   input  logic [7:0]  data_dat_in,
   output logic        we_dat_l,
   output logic        done
);

`ifdef DAT_FILL_VERIFY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, VERIFY = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1} state_t;
`endif

   state_t      state;
   logic [14:0] start_r;
   logic [7:0]  count_r;
   logic [7:0]  value_r;
   logic        inc_r;
   logic [14:0] cur_addr;
   logic [8:0]  remaining;   // 9 bits so a count of 0 can mean 256
   logic [7:0]  cur_val;
   logic        done_flag;
   logic        err;
   logic        verifying;

   logic       busy, step, last, ctrl_wr, start_cmd, abort_cmd;
   logic [8:0] load_rem;

   assign busy      = (state != IDLE);
   assign step      = busy && !cpu_dat_req;
   assign last      = (remaining == 9'd1);
   assign ctrl_wr   = reg_we && (reg_sel == 3'd3);
   assign abort_cmd = ctrl_wr && reg_wdata[2];
   // Abort takes precedence over a start carried in the same write.
   assign start_cmd = ctrl_wr && reg_wdata[0] && !reg_wdata[2];
   assign load_rem  = (count_r == 8'd0) ? 9'd256 : {1'b0, count_r};

`ifdef DAT_FILL_VERIFY_EN
   assign verifying = (state == VERIFY);
`else
   assign verifying = 1'b0;
   logic unused_rd;
   assign unused_rd = ^data_dat_in;
`endif

   always_ff @(posedge e or negedge _reset) begin
      if (!_reset) begin
         state     <= IDLE;
         start_r   <= '0;
         count_r   <= '0;
         value_r   <= '0;
         inc_r     <= 1'b0;
         cur_addr  <= '0;
         remaining <= '0;
         cur_val   <= '0;
         done_flag <= 1'b0;
         err       <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (reg_we) begin
                  case (reg_sel)
                     3'd0:    start_r[7:0]  <= reg_wdata;
                     3'd1:    start_r[14:8] <= reg_wdata[6:0];
                     3'd2:    count_r       <= reg_wdata;
                     3'd4:    value_r       <= reg_wdata;
                     default: ;
                  endcase
               end
               if (start_cmd) begin
                  state     <= FILL;
                  inc_r     <= reg_wdata[1];
                  done_flag <= 1'b0;
                  err       <= 1'b0;
                  cur_addr  <= start_r;
                  remaining <= load_rem;
                  cur_val   <= value_r;
               end
            end
            FILL: begin
               // The write presented this cycle always lands, even when
               // an abort arrives in the same cycle.
               if (step) begin
                  cur_addr  <= cur_addr + 15'd1;
                  remaining <= remaining - 9'd1;
                  if (inc_r) cur_val <= cur_val + 8'd1;
                  if (last && !abort_cmd) begin
`ifdef DAT_FILL_VERIFY_EN
                     state     <= VERIFY;
                     cur_addr  <= start_r;
                     remaining <= load_rem;
                     cur_val   <= value_r;
`else
                     state     <= IDLE;
                     done      <= 1'b1;
                     done_flag <= 1'b1;
`endif
                  end
               end
               if (abort_cmd) state <= IDLE;
            end
`ifdef DAT_FILL_VERIFY_EN
            VERIFY: begin
               if (step) begin
                  if (data_dat_in != cur_val) err <= 1'b1;
                  cur_addr  <= cur_addr + 15'd1;
                  remaining <= remaining - 9'd1;
                  if (inc_r) cur_val <= cur_val + 8'd1;
                  if (last && !abort_cmd) begin
                     state     <= IDLE;
                     done      <= 1'b1;
                     done_flag <= 1'b1;
                  end
               end
               if (abort_cmd) state <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

   assign we_dat_l     = (state == FILL) && !cpu_dat_req;
   assign dat_owner    = step;
   assign address_dat  = step ? cur_addr : 15'd0;
   assign data_dat_out = step ? cur_val : 8'd0;

   always_comb begin
      reg_rdata = 8'h00;
      case (reg_sel)
         3'd0:    reg_rdata = cur_addr[7:0];
         3'd1:    reg_rdata = {1'b0, cur_addr[14:8]};
         3'd2:    reg_rdata = remaining[7:0];
         3'd3:    reg_rdata = {busy, err, verifying, 4'b0000, done_flag};
         3'd4:    reg_rdata = cur_val;
         default: reg_rdata = 8'h00;
      endcase
   end

endmodule

// File: doc/dat_fill_ctrl.md
DAT_FILL_CTRL -- requirements
Module: dat_fill_ctrl

Interface
REQ-001 SHALL have clock `e`, input, 1 bit; all state updates on its rising edge.
REQ-002 SHALL have `_reset`, input, 1 bit; asynchronous, active-low reset.
REQ-003 SHALL have `reg_we`, input, 1 bit; CPU register write strobe, one cycle.
REQ-004 SHALL have `reg_sel`, input, 3 bits; register select: 0 start_lo, 1 start_hi, 2 count, 3 ctrl/status, 4 value.
REQ-005 SHALL have `reg_wdata`, input, 8 bits; register write data.
REQ-006 SHALL have `reg_rdata`, output, 8 bits; combinational readback of the register selected by `reg_sel`.
REQ-007 SHALL have `cpu_dat_req`, input, 1 bit; CPU is using the DAT port this cycle and has priority.
REQ-008 SHALL have `dat_owner`, output, 1 bit; high when the block drives the DAT port (busy & !cpu_dat_req).
REQ-009 SHALL have `address_dat`, output, 15 bits; DAT entry address, valid when `dat_owner` is high.
REQ-010 SHALL have `data_dat_out`, output, 8 bits; fill data for the DAT low byte.
REQ-011 SHALL have `data_dat_in`, input, 8 bits; DAT low-byte read data, asynchronous SRAM, same-cycle.
REQ-012 SHALL have `we_dat_l`, output, 1 bit; active-high low-byte write enable.
REQ-013 SHALL have `done`, output, 1 bit; one-cycle pulse on normal completion.

Function
REQ-014 SHALL implement states IDLE, FILL and VERIFY (VERIFY exists only per REQ-030).
REQ-015 In IDLE, writes to sel 0, 1, 2 and 4 SHALL load start[7:0], start[14:8] (from wdata[6:0]), count[7:0] and value[7:0]; in FILL/VERIFY these writes SHALL be ignored.
REQ-016 Ctrl writes: bit0=start, bit1=inc mode, bit2=abort; the inc bit SHALL latch only with start.
REQ-017 Start in IDLE SHALL go to FILL on that edge, clear the done_flag and err flags, and load cur_addr=start, remaining=count (0 means 256), cur_val=value; start while busy SHALL be ignored.
REQ-018 In FILL with !cpu_dat_req, `we_dat_l` SHALL be high combinationally that cycle, with address_dat=cur_addr and data_dat_out=cur_val.
REQ-019 On each such write edge: cur_addr+1 SHALL wrap at 15 bits (0x7FFF->0x0000); cur_val+1 SHALL wrap at 8 bits and update only in inc mode; remaining-1.
REQ-020 With cpu_dat_req high, `we_dat_l` SHALL be 0, `dat_owner` 0 and all counters SHALL hold.
REQ-021 The final write (remaining==1) SHALL move the block to IDLE (or VERIFY per REQ-030), pulse `done` for one cycle on entering IDLE and set done_flag.
REQ-022 Abort in FILL/VERIFY SHALL force IDLE on that edge with no `done` pulse; the write issued in that same cycle SHALL still complete; abort SHALL win over a simultaneous start.
REQ-023 Readback: sel0=cur_addr[7:0], sel1={1'b0,cur_addr[14:8]}, sel2=remaining[7:0], sel4=cur_val, sel3={busy,err,verifying,4'b0,done_flag}; all other selects SHALL read 0x00.
REQ-024 `we_dat_l` SHALL be 0 whenever the block is not in FILL.

Reset
REQ-025 `_reset` low SHALL asynchronously force IDLE and clear all registers and flags to 0.
REQ-026 With `_reset` low, `done`, `we_dat_l` and `dat_owner` SHALL be 0, `address_dat`=0 and `data_dat_out`=0.
REQ-027 Reset asserted mid-fill SHALL prevent any further write; entries already written SHALL not be restored.

Configuration
REQ-028 Macro DAT_FILL_VERIFY_EN SHALL select the read-back verify pass.
REQ-029 Without DAT_FILL_VERIFY_EN: no VERIFY state, err and verifying SHALL read 0, and FILL SHALL go directly to IDLE.
REQ-030 With DAT_FILL_VERIFY_EN: after the final write the block SHALL enter VERIFY and reload cur_addr, remaining and cur_val from the start registers.
REQ-031 In VERIFY, each cycle with !cpu_dat_req SHALL compare data_dat_in against cur_val, set a sticky err on mismatch and advance as in REQ-019 with no write.
REQ-032 VERIFY SHALL return to IDLE after `count` compares and pulse `done`.

Verification
REQ-033 start=0x0010, count=8, value=0x3F, inc=0 -> 8 consecutive writes of 0x3F at addresses 0x0010..0x0017, then `done` pulses for one cycle and status reads 0x01.
REQ-034 start=0x7FFE, count=4, value=0xFE, inc=1 -> writes at 0x7FFE/FE, 0x7FFF/FF, 0x0000/00, 0x0001/01.
REQ-035 count=8 with cpu_dat_req high in cycles 3-5 -> no `we_dat_l` in those cycles, 8 contiguous writes and `done` in cycle 11.
REQ-036 count=0 -> exactly 256 writes, and sel2 reads 0x00 afterwards.
REQ-037 Abort written in the cycle of the 4th write -> exactly 4 entries written, no `done` pulse, done_flag=0 and busy=0 on the next cycle.
REQ-038 With DAT_FILL_VERIFY_EN, count=4 and data_dat_in corrupted on the 3rd compare -> `done` pulses and status reads 0x41.
